wb_bus_interconnect: RTL and testbench

// - Parametrised single-master / NUM_SLAVES-slave Wishbone classic interconnect; replaces hand-wired OR-ed slave returns.
// - Decodes the master address against per-slave base/mask windows and gates cyc/stb to one slave only.
// - Muxes dat/ack/err/rty back from the selected slave and generates decode-error and timeout-error terminations.
// - Sits between control_unit (master) and uart_interface, frequency_counter and future slaves.

---
 rtl/wb_bus_interconnect_pkg.sv | 21 ++
 rtl/wb_bus_interconnect_if.sv | 52 +++++
 rtl/wb_bus_interconnect_addr_decoder.sv | 40 ++++
 rtl/wb_bus_interconnect.sv | 156 +++++++++++++++
 tb/tb_wb_bus_interconnect.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_bus_interconnect_pkg.sv
// Shared definitions for the Wishbone single-master interconnect.
//   DEF_AW / DEF_DW : default address / data widths
//   state_t         : interconnect FSM state encoding
//   cnt_width()     : bits needed to hold a counter value 0..max_val (never below 1)
package wb_bus_interconnect_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DECERR = 2'd2,
        ST_TOERR  = 2'd3
    } state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_bus_interconnect_if.sv
// Wishbone bus bundle between the control master, the interconnect and the slaves.
// Signal suffixes are relative to the interconnect (_i = into it, _o = out of it).
//   slave  : view taken by the interconnect (it is the slave of the control master)
//   master : mirror view for whatever drives the master request and the slave returns
//   m_*    : master-side request / response
//   s_*    : broadcast request copies, one-hot cyc/stb, flattened slave returns
interface wb_bus_interconnect_if
    import wb_bus_interconnect_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW
);
    logic [AW-1:0]            m_addr_i;
    logic [DW-1:0]            m_dat_i;
    logic [DW-1:0]            m_dat_o;
    logic                     m_we_i;
    logic [DW/8-1:0]          m_sel_i;
    logic                     m_cyc_i;
    logic                     m_stb_i;
    logic                     m_lock_i;
    logic                     m_ack_o;
    logic                     m_err_o;
    logic                     m_rty_o;

    logic [AW-1:0]            s_addr_o;
    logic [DW-1:0]            s_dat_o;
    logic                     s_we_o;
    logic [DW/8-1:0]          s_sel_o;
    logic                     s_lock_o;
    logic [NUM_SLAVES-1:0]    s_cyc_o;
    logic [NUM_SLAVES-1:0]    s_stb_o;
    logic [NUM_SLAVES*DW-1:0] s_dat_i;
    logic [NUM_SLAVES-1:0]    s_ack_i;
    logic [NUM_SLAVES-1:0]    s_err_i;
    logic [NUM_SLAVES-1:0]    s_rty_i;

    modport slave (
        input  m_addr_i, m_dat_i, m_we_i, m_sel_i, m_cyc_i, m_stb_i, m_lock_i,
               s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output m_dat_o, m_ack_o, m_err_o, m_rty_o,
               s_addr_o, s_dat_o, s_we_o, s_sel_o, s_lock_o, s_cyc_o, s_stb_o
    );

    modport master (
        output m_addr_i, m_dat_i, m_we_i, m_sel_i, m_cyc_i, m_stb_i, m_lock_i,
               s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  m_dat_o, m_ack_o, m_err_o, m_rty_o,
               s_addr_o, s_dat_o, s_we_o, s_sel_o, s_lock_o, s_cyc_o, s_stb_o
    );

endinterface

// File: rtl/wb_bus_interconnect_addr_decoder.sv
// Combinational address decoder: compares the address against every base/mask
// window and reports the lowest-indexed hit (overlapping windows resolve to
// the lower index) plus a miss flag when no window matches.
//   addr : address to decode
//   idx  : index of the winning slave (0 on miss)
//   miss : no window matched
module wb_bus_interconnect_addr_decoder
    import wb_bus_interconnect_pkg::*;
#(
    parameter int                     NUM_SLAVES = 4,
    parameter int                     AW         = DEF_AW,
    parameter int                     IW         = 2,
    parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK = '0
) (
    input  logic [AW-1:0] addr,
    output logic [IW-1:0] idx,
    output logic          miss
);

    logic [NUM_SLAVES-1:0] hit;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            hit[k] = ((addr & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]);
        end
    end

    // Scan from the top so the lowest matching index is the last one written.
    always_comb begin
        idx = '0;
        for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
            if (hit[k]) idx = IW'(k);
        end
    end

    assign miss = ~|hit;

endmodule

// File: rtl/wb_bus_interconnect.sv
// Single-master / NUM_SLAVES-slave Wishbone classic interconnect.
// Decodes each beat, gates cyc/stb to the selected slave only, muxes the
// selected slave's returns back, and terminates misses and stalled slaves
// with a one-cycle err pulse, keeping an error count and last error address.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   bus             : Wishbone bundle (slave modport)
//   err_count_o     : saturating count of decode + timeout errors
//   last_err_addr_o : address of the most recent decode/timeout error
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no beat in flight; decode a new request, hold locked cyc
// ST_ACTIVE | beat forwarded to slave sel_q; timer watching for a stall
// ST_DECERR | address matched no window; err pulse to master
// ST_TOERR  | selected slave did not terminate in time; err pulse
module wb_bus_interconnect
    import wb_bus_interconnect_pkg::*;
#(
    parameter int                       NUM_SLAVES     = 4,
    parameter int                       AW             = DEF_AW,
    parameter int                       DW             = DEF_DW,
    parameter logic [NUM_SLAVES*AW-1:0] SLV_BASE       = {32'h0000_3000, 32'h0000_2000,
                                                          32'h0000_1000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*AW-1:0] SLV_MASK       = {4{32'hFFFF_F000}},
    parameter int                       TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wb_bus_interconnect_if.slave bus,
    output logic [7:0]           err_count_o,
    output logic [AW-1:0]        last_err_addr_o
);

    localparam int IW = cnt_width(NUM_SLAVES - 1);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    state_t          state_q;
    logic [IW-1:0]   sel_q;
    logic [TW-1:0]   timer_q;
    logic            lock_q;

    logic [IW-1:0]   dec_idx;
    logic            dec_miss;
    logic            sel_ack, sel_err, sel_rty;
    logic [DW-1:0]   sel_dat;
    logic            active, idle, req, slv_term, lock_hold;

    wb_bus_interconnect_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (AW),
        .IW         (IW),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_dec (
        .addr (bus.m_addr_i),
        .idx  (dec_idx),
        .miss (dec_miss)
    );

    assign active   = (state_q == ST_ACTIVE);
    assign idle     = (state_q == ST_IDLE);
    assign req      = bus.m_cyc_i & bus.m_stb_i;
    assign slv_term = req & (sel_ack | sel_err | sel_rty);
    // A locked slave keeps cyc in IDLE until the master lets go of cyc or
    // strobes a beat that will land somewhere else.
    assign lock_hold = lock_q & bus.m_cyc_i &
                       ~(bus.m_stb_i & (dec_miss | (dec_idx != sel_q)));

    always_comb begin
        sel_ack = 1'b0;
        sel_err = 1'b0;
        sel_rty = 1'b0;
        sel_dat = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == IW'(k)) begin
                sel_ack = bus.s_ack_i[k];
                sel_err = bus.s_err_i[k];
                sel_rty = bus.s_rty_i[k];
                sel_dat = bus.s_dat_i[k*DW +: DW];
            end
        end
    end

    always_comb begin
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (sel_q == IW'(k)) begin
                bus.s_cyc_o[k] = (active & bus.m_cyc_i) | (idle & lock_hold);
                bus.s_stb_o[k] = active & req;
            end
        end
    end

    assign bus.s_addr_o = bus.m_addr_i;
    assign bus.s_dat_o  = bus.m_dat_i;
    assign bus.s_we_o   = bus.m_we_i;
    assign bus.s_sel_o  = bus.m_sel_i;
    assign bus.s_lock_o = bus.m_lock_i;

    assign bus.m_ack_o = active & req & sel_ack;
    assign bus.m_rty_o = active & req & sel_rty;
    assign bus.m_err_o = (active & req & sel_err) |
                         (state_q == ST_DECERR) | (state_q == ST_TOERR);
    assign bus.m_dat_o = active ? sel_dat : '0;

    // The stall timer is a down-counter loaded on entry to ACTIVE; reaching
    // the terminal count of 1 without a termination ends the beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= ST_IDLE;
            sel_q           <= '0;
            timer_q         <= '0;
            lock_q          <= 1'b0;
            err_count_o     <= '0;
            last_err_addr_o <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!bus.m_cyc_i) lock_q <= 1'b0;
                    if (req) begin
                        if (dec_miss) begin
                            lock_q  <= 1'b0;
                            state_q <= ST_DECERR;
                        end else begin
                            if (dec_idx != sel_q) lock_q <= 1'b0;
                            sel_q   <= dec_idx;
                            timer_q <= TW'(TIMEOUT_CYCLES);
                            state_q <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!bus.m_cyc_i) begin
                        lock_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (slv_term) begin
                        lock_q  <= bus.m_lock_i;
                        state_q <= ST_IDLE;
                    end else if ((TIMEOUT_CYCLES != 0) && (timer_q == TW'(1))) begin
                        state_q <= ST_TOERR;
                    end else begin
                        timer_q <= timer_q - TW'(1);
                    end
                end
                ST_DECERR, ST_TOERR: begin
                    last_err_addr_o <= bus.m_addr_i;
                    if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_bus_interconnect.sv
module tb_wb_bus_interconnect;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    // slave3 0x2000/4K, slave2 0x0000/256 (shadowed by slave0), slave1 0x1000/4K, slave0 0x0000/4K
    localparam logic [NS*AW-1:0] BASE = {32'h0000_2000, 32'h0000_0000, 32'h0000_1000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASK = {32'hFFFF_F000, 32'hFFFF_FF00, 32'hFFFF_F000, 32'hFFFF_F000};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  err_count;
    logic [31:0] last_err_addr;
    int          checks = 0;
    int          failures = 0;

    wb_bus_interconnect_if #(.NUM_SLAVES(NS), .AW(AW), .DW(DW)) bus ();

    wb_bus_interconnect #(
        .NUM_SLAVES     (NS),
        .AW             (AW),
        .DW             (DW),
        .SLV_BASE       (BASE),
        .SLV_MASK       (MASK),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .bus             (bus),
        .err_count_o     (err_count),
        .last_err_addr_o (last_err_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          slave;    // -1 = no window matches
        int          delay;    // cycles in ACTIVE before the slave responds
        int          resp;     // 0 ack, 1 err, 2 rty
        logic [31:0] rdata;
        logic [3:0]  exp_stb;
        logic        exp_ack;
        logic        exp_err;
        logic        exp_rty;
        logic [31:0] exp_dat;
        logic [7:0]  exp_cnt;
        logic [31:0] exp_last;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.m_addr_i = '0;
        bus.m_dat_i  = '0;
        bus.m_we_i   = 1'b0;
        bus.m_sel_i  = '0;
        bus.m_cyc_i  = 1'b0;
        bus.m_stb_i  = 1'b0;
        bus.m_lock_i = 1'b0;
        bus.s_dat_i  = '0;
        bus.s_ack_i  = '0;
        bus.s_err_i  = '0;
        bus.s_rty_i  = '0;
    endtask

    task automatic start_beat(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                              input logic lock);
        bus.m_addr_i = addr;
        bus.m_we_i   = we;
        bus.m_dat_i  = wdata;
        bus.m_sel_i  = 4'hF;
        bus.m_lock_i = lock;
        bus.m_cyc_i  = 1'b1;
        bus.m_stb_i  = 1'b1;
    endtask

    // Every slave drives distinct background data so a wrong mux choice shows up.
    task automatic slave_data(input int slave, input logic [31:0] rdata);
        for (int k = 0; k < NS; k++) begin
            bus.s_dat_i[k*DW +: DW] = (k == slave) ? rdata : (32'h1111_1111 * (k + 1));
        end
    endtask

    task automatic run_vec(input vec_t v, input int n);
        @(negedge clk);
        start_beat(v.addr, v.we, v.wdata, 1'b0);
        slave_data(v.slave, v.rdata);
        @(negedge clk);
        check($sformatf("v%0d_stb", n), 32'(bus.s_stb_o), 32'(v.exp_stb));
        if (v.slave >= 0) begin
            check($sformatf("v%0d_addr_bcast", n), bus.s_addr_o, v.addr);
            check($sformatf("v%0d_we_bcast", n), 32'(bus.s_we_o), 32'(v.we));
            for (int d = 0; d < v.delay; d++) begin
                check($sformatf("v%0d_no_ack_yet", n), 32'(bus.m_ack_o), 32'd0);
                @(negedge clk);
                check($sformatf("v%0d_stb_held", n), 32'(bus.s_stb_o), 32'(v.exp_stb));
            end
            case (v.resp)
                0:       bus.s_ack_i[v.slave] = 1'b1;
                1:       bus.s_err_i[v.slave] = 1'b1;
                default: bus.s_rty_i[v.slave] = 1'b1;
            endcase
            #1;
        end
        check($sformatf("v%0d_ack", n), 32'(bus.m_ack_o), 32'(v.exp_ack));
        check($sformatf("v%0d_err", n), 32'(bus.m_err_o), 32'(v.exp_err));
        check($sformatf("v%0d_rty", n), 32'(bus.m_rty_o), 32'(v.exp_rty));
        check($sformatf("v%0d_dat", n), bus.m_dat_o, v.exp_dat);
        @(negedge clk);
        clear_inputs();
        #1;
        check($sformatf("v%0d_stb_idle", n), 32'(bus.s_stb_o), 32'd0);
        check($sformatf("v%0d_err_idle", n), 32'(bus.m_err_o), 32'd0);
        check($sformatf("v%0d_err_count", n), 32'(err_count), 32'(v.exp_cnt));
        check($sformatf("v%0d_last_err", n), last_err_addr, v.exp_last);
    endtask

    initial begin
        //            addr          we    wdata         slv dly rsp rdata          stb     ack   err   rty   dat            cnt    last
        vecs[0] = '{32'h0000_1004, 1'b0, 32'h0,        1,  0,  0, 32'hDEAD_BEEF, 4'b0010, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 8'd0, 32'h0};
        vecs[1] = '{32'h0000_9000, 1'b1, 32'h0000_0077, -1, 0,  0, 32'h0,        4'b0000, 1'b0, 1'b1, 1'b0, 32'h0,        8'd1, 32'h0000_9000};
        vecs[2] = '{32'h0000_0010, 1'b0, 32'h0,        0,  2,  0, 32'h1234_5678, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 8'd1, 32'h0000_9000};
        vecs[3] = '{32'h0000_2008, 1'b0, 32'h0,        3,  1,  1, 32'hCAFE_F00D, 4'b1000, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 8'd1, 32'h0000_9000};
        vecs[4] = '{32'h0000_1FFC, 1'b1, 32'h0BAD_F00D, 1,  0,  2, 32'h0000_0042, 4'b0010, 1'b0, 1'b0, 1'b1, 32'h0000_0042, 8'd1, 32'h0000_9000};
        vecs[5] = '{32'h0000_3000, 1'b0, 32'h0,        -1, 0,  0, 32'h0,        4'b0000, 1'b0, 1'b1, 1'b0, 32'h0,        8'd2, 32'h0000_3000};
        vecs[6] = '{32'h0000_00FF, 1'b0, 32'h0,        0,  3,  0, 32'hA5A5_5A5A, 4'b0001, 1'b1, 1'b0, 1'b0, 32'hA5A5_5A5A, 8'd2, 32'h0000_3000};

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cyc", 32'(bus.s_cyc_o), 32'd0);
        check("rst_stb", 32'(bus.s_stb_o), 32'd0);
        check("rst_ack", 32'(bus.m_ack_o), 32'd0);
        check("rst_err", 32'(bus.m_err_o), 32'd0);
        check("rst_rty", 32'(bus.m_rty_o), 32'd0);
        check("rst_dat", bus.m_dat_o, 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_last_err", last_err_addr, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Timeout: slave0 never answers; 8 ACTIVE cycles, then a TOERR pulse.
        @(negedge clk);
        start_beat(32'h0000_0004, 1'b0, 32'h0, 1'b0);
        slave_data(0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("to_stb_c%0d", i), 32'(bus.s_stb_o), 32'b0001);
            check($sformatf("to_no_err_c%0d", i), 32'(bus.m_err_o), 32'd0);
        end
        @(negedge clk);
        check("to_stb_dropped", 32'(bus.s_stb_o), 32'd0);
        check("to_cyc_dropped", 32'(bus.s_cyc_o), 32'd0);
        check("to_err_pulse", 32'(bus.m_err_o), 32'd1);
        bus.s_ack_i[0] = 1'b1;
        #1;
        check("to_late_ack", 32'(bus.m_ack_o), 32'd0);
        @(negedge clk);
        clear_inputs();
        #1;
        check("to_err_end", 32'(bus.m_err_o), 32'd0);
        check("to_err_count", 32'(err_count), 32'd3);
        check("to_last_err", last_err_addr, 32'h0000_0004);

        // Abort: master drops cyc in the third ACTIVE cycle.
        @(negedge clk);
        start_beat(32'h0000_1008, 1'b0, 32'h0, 1'b0);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            check($sformatf("ab_cyc_c%0d", i), 32'(bus.s_cyc_o), 32'b0010);
        end
        @(negedge clk);
        bus.m_cyc_i = 1'b0;
        #1;
        check("ab_cyc_drop", 32'(bus.s_cyc_o), 32'd0);
        check("ab_stb_drop", 32'(bus.s_stb_o), 32'd0);
        check("ab_no_err", 32'(bus.m_err_o), 32'd0);
        @(negedge clk);
        clear_inputs();
        start_beat(32'h0000_2000, 1'b0, 32'h0, 1'b0);
        slave_data(3, 32'h0000_3333);
        @(negedge clk);
        check("ab_next_stb", 32'(bus.s_stb_o), 32'b1000);
        bus.s_ack_i[3] = 1'b1;
        #1;
        check("ab_next_ack", 32'(bus.m_ack_o), 32'd1);
        @(negedge clk);
        clear_inputs();
        #1;
        check("ab_err_count", 32'(err_count), 32'd3);

        // Lock: slave1 keeps cyc after termination while the master holds cyc.
        @(negedge clk);
        start_beat(32'h0000_1000, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        bus.s_ack_i[1] = 1'b1;
        #1;
        check("lk_ack", 32'(bus.m_ack_o), 32'd1);
        @(negedge clk);
        bus.s_ack_i = '0;
        bus.m_stb_i = 1'b0;
        #1;
        check("lk_cyc_held", 32'(bus.s_cyc_o), 32'b0010);
        check("lk_stb_idle", 32'(bus.s_stb_o), 32'd0);
        @(negedge clk);
        bus.m_cyc_i = 1'b0;
        #1;
        check("lk_cyc_release", 32'(bus.s_cyc_o), 32'd0);
        @(negedge clk);
        clear_inputs();

        // 300 decode errors: the counter saturates at 255.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start_beat(32'h0000_8000 + 32'(i * 4), 1'b1, 32'h0, 1'b0);
            @(negedge clk);
            @(negedge clk);
            clear_inputs();
        end
        #1;
        check("sat_err_count", 32'(err_count), 32'd255);
        check("sat_last_err", last_err_addr, 32'h0000_84AC);

        // Reset in the middle of an ACTIVE beat clears everything without a clock edge.
        @(negedge clk);
        start_beat(32'h0000_1004, 1'b0, 32'h0, 1'b0);
        slave_data(1, 32'h5555_AAAA);
        @(negedge clk);
        check("mr_pre_stb", 32'(bus.s_stb_o), 32'b0010);
        check("mr_pre_dat", bus.m_dat_o, 32'h5555_AAAA);
        bus.s_ack_i[1] = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mr_cyc", 32'(bus.s_cyc_o), 32'd0);
        check("mr_stb", 32'(bus.s_stb_o), 32'd0);
        check("mr_ack", 32'(bus.m_ack_o), 32'd0);
        check("mr_dat", bus.m_dat_o, 32'd0);
        check("mr_err_count", 32'(err_count), 32'd0);
        check("mr_last_err", last_err_addr, 32'd0);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
